cskipa_serial_adder: RTL



---
 rtl/cskipa_serial_adder_if.sv | 35 +++
 rtl/cskipa_serial_adder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cskipa_serial_adder_if.sv
// Handshake bundle for cskipa_serial_adder: operand side (in_*),
// result side (out_*, sum, cout, optional ovf under CSKIPA_SERIAL_OVF_EN).
interface cskipa_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSKIPA_SERIAL_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, i_add_term1, i_add_term2, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, i_add_term1, i_add_term2, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, i_add_term1, i_add_term2, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, i_add_term1, i_add_term2, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/cskipa_serial_adder.sv
// Nibble-serial WIDTH-bit adder around a 4-bit carry-skip slice.
// Ports: clk, rst (sync, active-high), bus (slave modport of
// cskipa_serial_adder_if: in_valid/in_ready, i_add_term1/2,
// out_valid/out_ready, sum, cout). Macro CSKIPA_SERIAL_OVF_EN adds ovf.
module CSkipA_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic       c1, c2, c3, c4;

  assign p  = a_i ^ b_i;
  assign g  = a_i & b_i;
  assign c1 = g[0];
  assign c2 = g[1] | (p[1] & c1);
  assign c3 = g[2] | (p[2] & c2);
  assign c4 = g[3] | (p[3] & c3);

  assign sum_o = p ^ {c3, c2, c1, 1'b0};
  // Skip path forwards the slice carry-in, which is tied to 0 here.
  assign cout_o = (&p) ? 1'b0 : c4;
endmodule

module cskipa_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  cskipa_serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
`ifdef CSKIPA_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  logic [3:0] sl_a, sl_b, sl_sum, inc_s;
  logic       sl_cout, inc_c, nxt_c, last;

  assign sl_a = a_q[{idx_q, 2'b00} +: 4];
  assign sl_b = b_q[{idx_q, 2'b00} +: 4];

  CSkipA_4bit u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .sum_o  (sl_sum),
    .cout_o (sl_cout)
  );

  // Re-inject the running carry; the two carries are exclusive.
  assign {inc_c, inc_s} = {1'b0, sl_sum} + {4'b0000, carry_q};
  assign nxt_c = sl_cout | inc_c;
  assign last  = (idx_q == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef CSKIPA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.i_add_term1;
            b_q     <= bus.i_add_term2;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef CSKIPA_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= inc_s;
          carry_q <= nxt_c;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            cout_q <= nxt_c;
`ifdef CSKIPA_SERIAL_OVF_EN
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (inc_s[3] != a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef CSKIPA_SERIAL_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule
